pair_assembler: RTL and testbench

Assembles a stream of W-bit symbols into (A, B) operand pairs for the two-operand datapath blocks. This is the write/assembly end of the operand path: the downstream operand selectors take a pair apart, and this block builds pairs from a serial symbol stream. Input and output each use a valid/ready handshake. A sync marker resynchronises the pairing, and a wrapping counter reports how many pairs have been delivered.

---
 rtl/pair_assembler.sv | 95 +++++++++
 tb/tb_pair_assembler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pair_assembler.sv
// Builds (A, B) operand pairs from a serial symbol stream with valid/ready on both sides.
// in_first marks operand A; out-of-order markers resynchronise pairing and pulse errSync.
module pair_assembler #(
    parameter int W  = 2,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          in_first,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_a,
    output logic [W-1:0]  out_b,
    output logic          err_sync,
    output logic [CW-1:0] pair_count
);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t        stateReg;
    logic [W-1:0]  aReg;
    logic [W-1:0]  bReg;
    logic          errReg;
    logic          inReadyReg;
    logic          outValidReg;
    logic [CW-1:0] countReg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg    <= WAIT_A;
            aReg        <= '0;
            bReg        <= '0;
            errReg      <= 1'b0;
            inReadyReg  <= 1'b1;
            outValidReg <= 1'b0;
            countReg    <= '0;
        end else begin
            errReg <= 1'b0;
            case (stateReg)
                WAIT_A: begin
                    if (in_valid) begin
                        if (in_first) begin
                            aReg     <= in_data;
                            stateReg <= WAIT_B;
                        end else begin
                            errReg <= 1'b1;
                        end
                    end
                end
                WAIT_B: begin
                    if (in_valid) begin
                        // A repeated first marker restarts the pair with the newer A
                        if (in_first) begin
                            aReg   <= in_data;
                            errReg <= 1'b1;
                        end else begin
                            bReg        <= in_data;
                            stateReg    <= FULL;
                            inReadyReg  <= 1'b0;
                            outValidReg <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        stateReg    <= WAIT_A;
                        inReadyReg  <= 1'b1;
                        outValidReg <= 1'b0;
                        countReg    <= countReg + 1'b1;
                    end
                end
                default: begin
                    stateReg    <= WAIT_A;
                    inReadyReg  <= 1'b1;
                    outValidReg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = inReadyReg;
    assign out_valid  = outValidReg;
    assign out_a      = aReg;
    assign out_b      = bReg;
    assign err_sync   = errReg;
    assign pair_count = countReg;

endmodule

// File: tb/tb_pair_assembler.sv
// Directed and randomized stimulus for pair_assembler, checked every cycle against a
// stream-level model (pending-pair queue, last captured operands, delivered-pair count).
module tb_pair_assembler;
    localparam int W  = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_first = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic          err_sync;
    logic [CW-1:0] pair_count;

    pair_assembler #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_first(in_first), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .err_sync(err_sync), .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;

    // Reference model: stream view of the protocol
    bit               haveA = 1'b0;
    logic [W-1:0]     lastA = '0;
    logic [W-1:0]     lastB = '0;
    logic [2*W-1:0]   pairQ[$];
    int               delivered = 0;
    bit               expErr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs, then compare all outputs
    task automatic tick();
        bit acc;
        bit del;
        logic [2*W-1:0] p;
        if (!rst_n) begin
            haveA = 1'b0;
            lastA = '0;
            lastB = '0;
            pairQ.delete();
            delivered = 0;
            expErr = 1'b0;
        end else begin
            acc = in_valid && (pairQ.size() == 0);
            del = (pairQ.size() != 0) && out_ready;
            expErr = acc && (in_first == haveA);
            if (acc) begin
                if (in_first) begin
                    haveA = 1'b1;
                    lastA = in_data;
                end else if (haveA) begin
                    lastB = in_data;
                    pairQ.push_back({lastA, in_data});
                    haveA = 1'b0;
                end
            end
            if (del) begin
                p = pairQ.pop_front();
                delivered = delivered + 1;
                $display("pair delivered #%0d: a=%0d b=%0d", delivered, p[2*W-1:W], p[W-1:0]);
            end
        end
        @(posedge clk);
        #1;
        chk("in_ready",   in_ready,   32'(pairQ.size() == 0));
        chk("out_valid",  out_valid,  32'(pairQ.size() != 0));
        chk("out_a",      out_a,      32'(lastA));
        chk("out_b",      out_b,      32'(lastB));
        chk("err_sync",   err_sync,   32'(expErr));
        chk("pair_count", pair_count, 32'(delivered % (1 << CW)));
    endtask

    task automatic send(input bit first, input logic [W-1:0] data);
        in_valid = 1'b1;
        in_first = first;
        in_data  = data;
        tick();
        in_valid = 1'b0;
        in_first = 1'($urandom);
        in_data  = W'($urandom);
    endtask

    task automatic gaps(input int maxGap);
        int n;
        n = $urandom_range(maxGap, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held two cycles
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Basic pair
        out_ready = 1'b1;
        send(1'b1, 2'b10);
        send(1'b0, 2'b01);
        tick();
        tick();

        // Backpressure for five cycles
        out_ready = 1'b0;
        send(1'b1, 2'd3);
        send(1'b0, 2'd0);
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b1;
        tick();
        tick();

        // Framing errors: stray B, then restart in WAIT_B
        send(1'b0, 2'd1);
        send(1'b1, 2'd1);
        send(1'b1, 2'd2);
        send(1'b0, 2'd3);
        tick();

        // Wrap with random gaps
        doReset();
        for (int k = 0; k < 5; k++) begin
            gaps(3);
            send(1'b1, W'($urandom));
            gaps(3);
            send(1'b0, W'($urandom));
            tick();
        end

        // Reset in WAIT_B with pair_count = 2
        doReset();
        for (int k = 0; k < 2; k++) begin
            send(1'b1, W'($urandom));
            send(1'b0, W'($urandom));
            tick();
        end
        send(1'b1, 2'd1);
        doReset();
        send(1'b1, 2'd2);
        send(1'b0, 2'd1);
        tick();

        // Reset in FULL with pair_count = 2
        doReset();
        for (int k = 0; k < 2; k++) begin
            send(1'b1, W'($urandom));
            send(1'b0, W'($urandom));
            tick();
        end
        out_ready = 1'b0;
        send(1'b1, 2'd3);
        send(1'b0, 2'd2);
        tick();
        doReset();
        out_ready = 1'b1;
        send(1'b1, 2'd1);
        send(1'b0, 2'd3);
        tick();

        // Fully random traffic, including occasional reset
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            in_first  = 1'($urandom);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(2, 0) != 0);
            rst_n     = ($urandom_range(60, 0) != 0);
            tick();
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
